encoder_4x2_drain: RTL and testbench



---
 rtl/encoder_pkg.sv | 23 ++
 rtl/encoder_4x2_drain_lsb_priority_encoder.sv | 35 +++
 rtl/encoder_4x2_drain.sv | 79 +++++++
 tb/tb_encoder_4x2_drain.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential priority encoder slice:
// drain FSM state encoding and a ceiling-log2 helper for index widths.
package encoder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } enc_state_t;

    // Ceiling log2 for sizing index buses; callers guarantee n >= 2.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_4x2_drain_lsb_priority_encoder.sv
// Purely combinational lowest-set-bit encoder: reports the position of the
// lowest set bit, whether any bit is set, and whether exactly one bit is set.
module lsb_priority_encoder
    import encoder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one_hot
);

    logic [WIDTH-1:0] lowest;
    logic [WIDTH-1:0] rest;

    // Isolate the lowest set bit and the word with that bit removed.
    assign lowest = vec & (~vec + WIDTH'(1));
    assign rest   = vec & (vec - WIDTH'(1));

    assign any     = |vec;
    assign one_hot = any && (rest == '0);

    // OR together the positions of the (at most one) isolated bit.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder_4x2_drain.sv
// Sequential priority encoder: accepts a request word, then emits the binary
// index of each set bit, lowest first, one per output handshake. All-zero
// words are discarded with a one-cycle zero_drop pulse.
module encoder_4x2_drain
    import encoder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_drop
);

    enc_state_t       state_reg;
    logic [WIDTH-1:0] pending_reg;
    logic             zero_drop_reg;
    logic             pend_any;
    logic             pend_one_hot;

    lsb_priority_encoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pe (
        .vec     (pending_reg),
        .idx     (out_idx),
        .any     (pend_any),
        .one_hot (pend_one_hot)
    );

    // Handshake outputs come from state only; in_ready is also held low
    // while reset is asserted so nothing is offered to a block in reset.
    assign in_ready  = rst_n && (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DRAIN);
    assign out_last  = pend_one_hot;
    assign zero_drop = zero_drop_reg;

    // Drain FSM: capture a word in IDLE, clear one bit per handshake in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= '0;
            zero_drop_reg <= 1'b0;
        end else begin
            zero_drop_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (in_req != '0) begin
                            pending_reg <= in_req;
                            state_reg   <= ST_DRAIN;
                        end else begin
                            zero_drop_reg <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        pending_reg <= pending_reg & (pending_reg - WIDTH'(1));
                        // An empty pending word cannot occur in normal
                        // operation; leaving DRAIN on it avoids a lockup.
                        if (pend_one_hot || !pend_any) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_4x2_drain.sv
// Self-checking bench for encoder_4x2_drain at WIDTH=8: a per-cycle vector
// table for drain/backpressure/zero-word behaviour plus hand sequences for
// reset, a full word with a queued follower, and reset mid-drain.
module tb_encoder_4x2_drain;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_req;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             zero_drop;

    int checks;
    int errors;

    encoder_4x2_drain #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_drop (zero_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] req;
        logic             ordy;
        logic             e_rdy;
        logic             e_val;
        logic [IDX_W-1:0] e_idx;
        logic             e_last;
        logic             e_zd;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic iv, input logic [WIDTH-1:0] req,
                                input logic ordy, input logic e_rdy,
                                input logic e_val, input logic [IDX_W-1:0] e_idx,
                                input logic e_last, input logic e_zd);
        vec_t v;
        v.iv = iv; v.req = req; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_idx = e_idx;
        v.e_last = e_last; v.e_zd = e_zd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rdy, input logic e_val,
                              input logic [IDX_W-1:0] e_idx, input logic e_last,
                              input logic e_zd);
        check({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_val));
        check({tag, ".out_idx"},   32'(out_idx),   32'(e_idx));
        check({tag, ".out_last"},  32'(out_last),  32'(e_last));
        check({tag, ".zero_drop"}, 32'(zero_drop), 32'(e_zd));
        $display("[%0t] %s rdy=%0b val=%0b idx=%0d last=%0b zd=%0b", $time, tag,
                 in_ready, out_valid, out_idx, out_last, zero_drop);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_req    = 8'h55;
        out_ready = 1'b1;

        // Vector table: inputs driven this cycle, outputs expected before the edge.
        //           iv    req    ordy rdy  val  idx  last zd
        tbl[0]  = mk(1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Reset held for 3 cycles with in_valid asserted.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_outs($sformatf("reset%0d", c), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_req   = 8'h00;
        rst_n    = 1'b1;
        #1;
        check_outs("release", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Table-driven multi-hot drain, backpressure and zero-word cases.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            in_req    = tbl[i].req;
            out_ready = tbl[i].ordy;
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_val,
                       tbl[i].e_idx, tbl[i].e_last, tbl[i].e_zd);
        end

        // Full word 8'hFF, with a follower word 8'h81 held during the drain.
        @(negedge clk);
        in_valid  = 1'b1;
        in_req    = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        in_req = 8'h81;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_outs($sformatf("full%0d", k), 1'b0, 1'b1, IDX_W'(k), (k == 7), 1'b0);
            @(negedge clk);
        end
        #1;
        check_outs("follow_accept", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_req   = 8'h00;
        #1;
        check_outs("follow0", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outs("follow7", 1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check_outs("follow_idle", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Reset asserted after the 2nd index of 8'hFF has been taken.
        in_valid = 1'b1;
        in_req   = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        in_req   = 8'h00;
        #1;
        check_outs("mid0", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outs("mid1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outs("mid2", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs("mid_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("mid_release", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check_outs($sformatf("post_rst%0d", c), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
